store_commit_buffer: RTL and testbench
======================================

Name: store_commit_buffer

Overview:
- Holds executed STUR results (address, data, ROB index) between the load/store functional unit and dmem, so stores reach memory only after ROB commit.
- Drains committed stores in program order, one per cycle, to the dmem write port.
- Discards uncommitted stores on a mispredict flush.
- Offers address-match information to younger loads; forwarding is optional.

Parameters:
- DEPTH, 4, number of store entries; power of two, ≥2.
- ADDR_W, 64, store/load address width; fixed at `GPR_SIZE.

Ports:
- in_clk  input  1  clock.
- in_rst  input  1  reset; synchronous, active-high.
- in_fu_st_valid  input  1  LS unit presents an executed STUR this cycle.
- in_fu_st_addr  input  `GPR_SIZE  store address.
- in_fu_st_data  input  `GPR_SIZE  store data.
- in_fu_st_rob_index  input  `ROB_IDX_SIZE  ROB index of the store.
- out_fu_st_ready  output  1  buffer can accept a store.
- in_rob_commit_valid  input  1  ROB retires an instruction this cycle.
- in_rob_commit_index  input  `ROB_IDX_SIZE  ROB index being retired.
- in_flush  input  1  mispredict; drop all uncommitted stores.
- in_ld_addr  input  `GPR_SIZE  address of the load currently in LS.
- out_ld_conflict  output  1  some buffered or pending store matches in_ld_addr.
- out_ld_fwd_hit  output  1  forwarded data is valid.
- out_ld_fwd_value  output  `GPR_SIZE  forwarded store data.
- out_dmem_w_enable  output  1  write dmem this cycle.
- out_dmem_addr  output  `GPR_SIZE  dmem write address.
- out_dmem_wval  output  `GPR_SIZE  dmem write data.
- out_empty  output  1  no entries and no pending write.

Behaviour:
- Storage: circular FIFO with head, tail and commit pointers, each clog2(DEPTH) bits, wrapping modulo DEPTH, plus a count of 0..DEPTH.
- Entry fields: valid, committed, addr, data, rob_index.
- Reset: all entries invalid; pointers and count 0; out_dmem_w_enable=0; out_dmem_addr=0; out_dmem_wval=0; out_fu_st_ready=1; out_empty=1; ld outputs 0.
- out_fu_st_ready = (count < DEPTH), from registered state only; no same-cycle bypass with drain.
- Push: on in_fu_st_valid & out_fu_st_ready, write the entry at tail, committed=0, tail+1. A push while full is ignored; the LS unit must hold it.
- Commit: on in_rob_commit_valid, if the entry at the commit pointer is valid, uncommitted, and its rob_index == in_rob_commit_index, set committed=1 and advance the commit pointer. Any other commit index is a non-store retire and is ignored.
- Drain: each cycle, if the head entry is committed, pop it and register addr/data into out_dmem_*, with out_dmem_w_enable=1 for exactly one cycle. Otherwise out_dmem_w_enable=0.
- Latency: commit in cycle N → out_dmem_w_enable high in cycle N+1 at the earliest. Sustained throughput is one store per cycle.
- Pending-write slot: the registered out_dmem_* is treated as a buffer position until the following edge, for conflict and forwarding.
- Flush: tail := commit pointer; uncommitted entries are invalidated; committed entries and the pending write are retained and still drain. count is recomputed.
- Simultaneous events:
  - flush + push: the push is dropped.
  - commit + flush: the commit is applied first, so that entry survives.
  - push + drain: both occur; count is unchanged.
  - commit of an entry pushed in the same cycle: not possible; the ROB commits only after done.
- Conflict: exact 64-bit compare of in_ld_addr against all valid entries plus the pending-write slot; combinational.
- Reset asserted mid-drain: buffered stores are lost; no write is issued in the reset cycle or the following cycle.

Optional Feature:
- Macro STORE_BUF_FWD_EN.
- Defined: on conflict, out_ld_fwd_hit=1 and out_ld_fwd_value=data of the youngest matching store. Age order, youngest first: entries tail-1 back to head, then the pending slot.
- Undefined: out_ld_fwd_hit=0 and out_ld_fwd_value=0; LS must stall the load while out_ld_conflict=1.

Decomposition:
- Shared package (data_structures.sv): store_buf_entry_t struct (valid, committed, addr, data, rob_index); `GPR_SIZE and `ROB_IDX_SIZE are already defined there.
- One sub-module: store_buf_match, a combinational youngest-match priority selector taking the entry array, head/tail and the pending slot; returns conflict, hit and value.

Test Plan:
- Reset, then push store addr=0x10, data=0xAB, rob=3; commit index 3 → out_dmem_w_enable=1 with addr 0x10, wval 0xAB exactly one cycle after commit; out_empty=1 afterwards.
- Push 4 stores (rob 1-4) without commit → out_fu_st_ready=0. A 5th push is ignored. Commit 1 → that store drains, then ready=1 again. Verify FIFO pointer wrap through 8 total stores.
- Push rob 5 and 6; commit 5 and assert in_flush in the same cycle → rob 5 drains to dmem; rob 6 never written; count=0.
- With STORE_BUF_FWD_EN: push addr 0x20 data 1, then addr 0x20 data 2; load addr 0x20 → hit=1, value=2. Load addr 0x28 → hit=0, conflict=0.
- Without STORE_BUF_FWD_EN: same stimulus → conflict=1, hit=0, value=0.
- Commit index 9 with no matching store → no state change; push and drain in the same cycle while count=2 → count stays 2.

Source files
------------

// File: rtl/store_commit_buffer_pkg.sv
// Shared types for the store commit buffer: entry layout, datapath widths and match helper.
package store_commit_buffer_pkg;

  localparam int unsigned GprSize    = 64;
  localparam int unsigned RobIdxSize = 5;

  typedef struct packed {
    logic                  valid;
    logic                  committed;
    logic [GprSize-1:0]    addr;
    logic [GprSize-1:0]    data;
    logic [RobIdxSize-1:0] rob_index;
  } store_buf_entry_t;

  function automatic logic entry_addr_hit(input store_buf_entry_t ent,
                                          input logic [GprSize-1:0] addr);
    return ent.valid && (ent.addr == addr);
  endfunction

endpackage

// File: rtl/store_commit_buffer_if.sv
// Bus between the LS unit / ROB (master) and the store commit buffer (slave).
interface store_commit_buffer_if;
  import store_commit_buffer_pkg::*;

  logic                  in_fu_st_valid;
  logic [GprSize-1:0]    in_fu_st_addr;
  logic [GprSize-1:0]    in_fu_st_data;
  logic [RobIdxSize-1:0] in_fu_st_rob_index;
  logic                  out_fu_st_ready;
  logic                  in_rob_commit_valid;
  logic [RobIdxSize-1:0] in_rob_commit_index;
  logic                  in_flush;
  logic [GprSize-1:0]    in_ld_addr;
  logic                  out_ld_conflict;
  logic                  out_ld_fwd_hit;
  logic [GprSize-1:0]    out_ld_fwd_value;
  logic                  out_dmem_w_enable;
  logic [GprSize-1:0]    out_dmem_addr;
  logic [GprSize-1:0]    out_dmem_wval;
  logic                  out_empty;

  modport master (
    output in_fu_st_valid, in_fu_st_addr, in_fu_st_data, in_fu_st_rob_index,
    output in_rob_commit_valid, in_rob_commit_index, in_flush, in_ld_addr,
    input  out_fu_st_ready, out_ld_conflict, out_ld_fwd_hit, out_ld_fwd_value,
    input  out_dmem_w_enable, out_dmem_addr, out_dmem_wval, out_empty
  );

  modport slave (
    input  in_fu_st_valid, in_fu_st_addr, in_fu_st_data, in_fu_st_rob_index,
    input  in_rob_commit_valid, in_rob_commit_index, in_flush, in_ld_addr,
    output out_fu_st_ready, out_ld_conflict, out_ld_fwd_hit, out_ld_fwd_value,
    output out_dmem_w_enable, out_dmem_addr, out_dmem_wval, out_empty
  );

endinterface

// File: rtl/store_commit_buffer_match.sv
// store_buf_match: youngest-first address match over buffered stores and the pending write.
// Forwarding data is produced only when STORE_BUF_FWD_EN is defined.
module store_buf_match
  import store_commit_buffer_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth)
) (
  input  store_buf_entry_t   ent_i [Depth],
  input  logic [PtrW-1:0]    tail_i,
  input  logic               pend_valid_i,
  input  logic [GprSize-1:0] pend_addr_i,
  input  logic [GprSize-1:0] pend_data_i,
  input  logic [GprSize-1:0] ld_addr_i,
  output logic               conflict_o,
  output logic               hit_o,
  output logic [GprSize-1:0] value_o
);

  logic               any_hit;
  logic [GprSize-1:0] sel_data;
  logic [PtrW-1:0]    idx;
  logic               unused_bits;

  // Scan oldest to youngest so the last match (youngest store) wins.
  always_comb begin
    any_hit  = 1'b0;
    sel_data = '0;
    idx      = '0;
    if (pend_valid_i && (pend_addr_i == ld_addr_i)) begin
      any_hit  = 1'b1;
      sel_data = pend_data_i;
    end
    for (int k = int'(Depth) - 1; k >= 0; k--) begin
      idx = tail_i - PtrW'(k) - PtrW'(1);
      if (entry_addr_hit(ent_i[idx], ld_addr_i)) begin
        any_hit  = 1'b1;
        sel_data = ent_i[idx].data;
      end
    end
  end

  always_comb begin
    unused_bits = ^pend_data_i;
    for (int i = 0; i < int'(Depth); i++) begin
      unused_bits = unused_bits ^ (^ent_i[i]);
    end
  end

  assign conflict_o = any_hit;

`ifdef STORE_BUF_FWD_EN
  assign hit_o   = any_hit;
  assign value_o = sel_data;
`else
  assign hit_o   = 1'b0;
  assign value_o = '0;
`endif

endmodule

// File: rtl/store_commit_buffer.sv
// Store commit buffer: holds executed stores until ROB commit, drains them in order to dmem.
// Optional load forwarding is enabled by the STORE_BUF_FWD_EN macro.
module store_commit_buffer
  import store_commit_buffer_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input logic                 in_clk,
  input logic                 in_rst,
  store_commit_buffer_if.slave bus
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  store_buf_entry_t   ent_q [Depth];
  store_buf_entry_t   ent_d [Depth];
  logic [PtrW-1:0]    head_q, head_d;
  logic [PtrW-1:0]    tail_q, tail_d;
  logic [PtrW-1:0]    cmt_q, cmt_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               dmem_we_q, dmem_we_d;
  logic [GprSize-1:0] dmem_addr_q, dmem_addr_d;
  logic [GprSize-1:0] dmem_wval_q, dmem_wval_d;

  logic st_ready;
  logic cmt_hit;
  logic drain;

  assign st_ready = (count_q < CntW'(Depth));

  assign cmt_hit = bus.in_rob_commit_valid && ent_q[cmt_q].valid && !ent_q[cmt_q].committed &&
                   (ent_q[cmt_q].rob_index == bus.in_rob_commit_index);

  // A head entry committed this very cycle drains immediately.
  assign drain = ent_q[head_q].valid &&
                 (ent_q[head_q].committed || (cmt_hit && (cmt_q == head_q)));

  always_comb begin
    ent_d       = ent_q;
    head_d      = head_q;
    tail_d      = tail_q;
    cmt_d       = cmt_q;
    count_d     = '0;
    dmem_we_d   = drain;
    dmem_addr_d = dmem_addr_q;
    dmem_wval_d = dmem_wval_q;

    if (cmt_hit) begin
      ent_d[cmt_q].committed = 1'b1;
      cmt_d                  = cmt_q + PtrW'(1);
    end

    if (drain) begin
      dmem_addr_d         = ent_q[head_q].addr;
      dmem_wval_d         = ent_q[head_q].data;
      ent_d[head_q].valid = 1'b0;
      head_d              = head_q + PtrW'(1);
    end

    // Flush wins over a concurrent push; the commit above is already applied.
    if (bus.in_flush) begin
      tail_d = cmt_d;
      for (int i = 0; i < int'(Depth); i++) begin
        if (!ent_d[i].committed) begin
          ent_d[i].valid = 1'b0;
        end
      end
    end else if (bus.in_fu_st_valid && st_ready) begin
      ent_d[tail_q] = '{valid:     1'b1,
                        committed: 1'b0,
                        addr:      bus.in_fu_st_addr,
                        data:      bus.in_fu_st_data,
                        rob_index: bus.in_fu_st_rob_index};
      tail_d        = tail_q + PtrW'(1);
    end

    for (int i = 0; i < int'(Depth); i++) begin
      count_d = count_d + CntW'(ent_d[i].valid);
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      for (int i = 0; i < int'(Depth); i++) begin
        ent_q[i] <= '0;
      end
      head_q      <= '0;
      tail_q      <= '0;
      cmt_q       <= '0;
      count_q     <= '0;
      dmem_we_q   <= 1'b0;
      dmem_addr_q <= '0;
      dmem_wval_q <= '0;
    end else begin
      ent_q       <= ent_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      cmt_q       <= cmt_d;
      count_q     <= count_d;
      dmem_we_q   <= dmem_we_d;
      dmem_addr_q <= dmem_addr_d;
      dmem_wval_q <= dmem_wval_d;
    end
  end

  store_buf_match #(
    .Depth(Depth)
  ) u_match (
    .ent_i       (ent_q),
    .tail_i      (tail_q),
    .pend_valid_i(dmem_we_q),
    .pend_addr_i (dmem_addr_q),
    .pend_data_i (dmem_wval_q),
    .ld_addr_i   (bus.in_ld_addr),
    .conflict_o  (bus.out_ld_conflict),
    .hit_o       (bus.out_ld_fwd_hit),
    .value_o     (bus.out_ld_fwd_value)
  );

  assign bus.out_fu_st_ready   = st_ready;
  // Suppress a write already registered when reset arrives.
  assign bus.out_dmem_w_enable = dmem_we_q & ~in_rst;
  assign bus.out_dmem_addr     = dmem_addr_q;
  assign bus.out_dmem_wval     = dmem_wval_q;
  assign bus.out_empty         = (count_q == '0) && !dmem_we_q;

endmodule

// File: tb/tb_store_commit_buffer.sv
// Directed bench for store_commit_buffer with a dmem-write scoreboard.
module tb_store_commit_buffer;
  import store_commit_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  store_commit_buffer_if bus ();

  store_commit_buffer #(
    .Depth(4)
  ) dut (
    .in_clk(clk),
    .in_rst(rst),
    .bus   (bus)
  );

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and score any dmem write seen after the edge.
  task automatic tick();
    wr_t w;
    @(posedge clk);
    #1;
    if (bus.out_dmem_w_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 64'(exp_q.size()), 64'd1);
      end else begin
        w = exp_q.pop_front();
        chk("dmem_addr", bus.out_dmem_addr, w.addr);
        chk("dmem_wval", bus.out_dmem_wval, w.data);
      end
    end
  endtask

  task automatic push_st(input logic [63:0] addr, input logic [63:0] data, input int rob);
    bus.in_fu_st_valid     = 1'b1;
    bus.in_fu_st_addr      = addr;
    bus.in_fu_st_data      = data;
    bus.in_fu_st_rob_index = RobIdxSize'(rob);
    tick();
    bus.in_fu_st_valid = 1'b0;
  endtask

  task automatic commit_exp(input int rob, input logic [63:0] addr, input logic [63:0] data);
    exp_q.push_back('{addr: addr, data: data});
    bus.in_rob_commit_valid = 1'b1;
    bus.in_rob_commit_index = RobIdxSize'(rob);
    tick();
    bus.in_rob_commit_valid = 1'b0;
    chk("commit_latency", 64'(bus.out_dmem_w_enable), 64'd1);
  endtask

  initial begin
    rst                     = 1'b1;
    bus.in_fu_st_valid      = 1'b0;
    bus.in_fu_st_addr       = '0;
    bus.in_fu_st_data       = '0;
    bus.in_fu_st_rob_index  = '0;
    bus.in_rob_commit_valid = 1'b0;
    bus.in_rob_commit_index = '0;
    bus.in_flush            = 1'b0;
    bus.in_ld_addr          = 64'h28;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_ready", 64'(bus.out_fu_st_ready), 64'd1);
    chk("rst_empty", 64'(bus.out_empty), 64'd1);
    chk("rst_we", 64'(bus.out_dmem_w_enable), 64'd0);
    chk("rst_addr", bus.out_dmem_addr, 64'd0);
    chk("rst_wval", bus.out_dmem_wval, 64'd0);
    chk("rst_conflict", 64'(bus.out_ld_conflict), 64'd0);
    chk("rst_hit", 64'(bus.out_ld_fwd_hit), 64'd0);
    chk("rst_value", bus.out_ld_fwd_value, 64'd0);
    chk("rst_count", 64'(dut.count_q), 64'd0);

    // Single store, commit, drain.
    push_st(64'h10, 64'hAB, 3);
    chk("one_not_empty", 64'(bus.out_empty), 64'd0);
    commit_exp(3, 64'h10, 64'hAB);
    tick();
    chk("one_we_pulse", 64'(bus.out_dmem_w_enable), 64'd0);
    chk("one_empty", 64'(bus.out_empty), 64'd1);

    // Fill, overflow attempt, drain with pointer wrap.
    for (int i = 1; i <= 4; i++) push_st(64'h100 + 64'(8 * i), 64'h1000 + 64'(i), i);
    chk("full_ready", 64'(bus.out_fu_st_ready), 64'd0);
    chk("full_count", 64'(dut.count_q), 64'd4);
    push_st(64'h1F8, 64'hDEAD, 7);
    chk("overflow_count", 64'(dut.count_q), 64'd4);
    chk("overflow_ready", 64'(bus.out_fu_st_ready), 64'd0);
    commit_exp(1, 64'h108, 64'h1001);
    chk("ready_again", 64'(bus.out_fu_st_ready), 64'd1);
    for (int i = 2; i <= 4; i++) commit_exp(i, 64'h100 + 64'(8 * i), 64'h1000 + 64'(i));
    for (int k = 8; k <= 11; k++) push_st(64'h180 + 64'(8 * k), 64'h2000 + 64'(k), k);
    chk("wrap_full_ready", 64'(bus.out_fu_st_ready), 64'd0);
    for (int k = 8; k <= 11; k++) commit_exp(k, 64'h180 + 64'(8 * k), 64'h2000 + 64'(k));
    tick();
    chk("wrap_empty", 64'(bus.out_empty), 64'd1);

    // Commit and flush together: rob 5 survives, rob 6 is discarded.
    push_st(64'h300, 64'h55, 5);
    push_st(64'h308, 64'h66, 6);
    bus.in_flush = 1'b1;
    commit_exp(5, 64'h300, 64'h55);
    bus.in_flush = 1'b0;
    chk("flush_count", 64'(dut.count_q), 64'd0);
    tick();
    tick();
    chk("flush_empty", 64'(bus.out_empty), 64'd1);
    chk("flush_ready", 64'(bus.out_fu_st_ready), 64'd1);

    // Push during flush is dropped.
    bus.in_flush = 1'b1;
    push_st(64'h600, 64'h99, 20);
    bus.in_flush = 1'b0;
    chk("flush_push_count", 64'(dut.count_q), 64'd0);

    // Load conflict and forwarding, including the pending-write slot.
    push_st(64'h20, 64'h1, 12);
    push_st(64'h20, 64'h2, 13);
    bus.in_ld_addr = 64'h20;
    #1;
    chk("ld_conflict", 64'(bus.out_ld_conflict), 64'd1);
`ifdef STORE_BUF_FWD_EN
    chk("ld_hit", 64'(bus.out_ld_fwd_hit), 64'd1);
    chk("ld_value", bus.out_ld_fwd_value, 64'd2);
`else
    chk("ld_hit", 64'(bus.out_ld_fwd_hit), 64'd0);
    chk("ld_value", bus.out_ld_fwd_value, 64'd0);
`endif
    bus.in_ld_addr = 64'h28;
    #1;
    chk("ld_miss_conflict", 64'(bus.out_ld_conflict), 64'd0);
    chk("ld_miss_hit", 64'(bus.out_ld_fwd_hit), 64'd0);
    bus.in_ld_addr = 64'h20;
    commit_exp(12, 64'h20, 64'h1);
    chk("pend_conflict_a", 64'(bus.out_ld_conflict), 64'd1);
`ifdef STORE_BUF_FWD_EN
    chk("pend_value_a", bus.out_ld_fwd_value, 64'd2);
`endif
    commit_exp(13, 64'h20, 64'h2);
    chk("pend_conflict_b", 64'(bus.out_ld_conflict), 64'd1);
`ifdef STORE_BUF_FWD_EN
    chk("pend_value_b", bus.out_ld_fwd_value, 64'd2);
`else
    chk("pend_value_b", bus.out_ld_fwd_value, 64'd0);
`endif
    tick();
    chk("pend_gone", 64'(bus.out_ld_conflict), 64'd0);
    bus.in_ld_addr = 64'h28;

    // Non-store retire, then push and drain in the same cycle.
    push_st(64'h400, 64'h44, 14);
    push_st(64'h408, 64'h45, 15);
    bus.in_rob_commit_valid = 1'b1;
    bus.in_rob_commit_index = RobIdxSize'(9);
    tick();
    bus.in_rob_commit_valid = 1'b0;
    chk("bad_commit_count", 64'(dut.count_q), 64'd2);
    chk("bad_commit_we", 64'(bus.out_dmem_w_enable), 64'd0);
    bus.in_fu_st_valid     = 1'b1;
    bus.in_fu_st_addr      = 64'h410;
    bus.in_fu_st_data      = 64'h46;
    bus.in_fu_st_rob_index = RobIdxSize'(16);
    commit_exp(14, 64'h400, 64'h44);
    bus.in_fu_st_valid = 1'b0;
    chk("push_drain_count", 64'(dut.count_q), 64'd2);
    commit_exp(15, 64'h408, 64'h45);
    commit_exp(16, 64'h410, 64'h46);
    tick();
    chk("pd_empty", 64'(bus.out_empty), 64'd1);

    // Reset in the middle of a drain loses buffered stores.
    push_st(64'h500, 64'h77, 17);
    push_st(64'h508, 64'h78, 18);
    commit_exp(17, 64'h500, 64'h77);
    rst                     = 1'b1;
    bus.in_rob_commit_valid = 1'b1;
    bus.in_rob_commit_index = RobIdxSize'(18);
    #1;
    chk("rst_cycle_we", 64'(bus.out_dmem_w_enable), 64'd0);
    tick();
    rst                     = 1'b0;
    bus.in_rob_commit_valid = 1'b0;
    chk("rst_edge_we", 64'(bus.out_dmem_w_enable), 64'd0);
    tick();
    chk("rst_after_we", 64'(bus.out_dmem_w_enable), 64'd0);
    chk("rst_after_count", 64'(dut.count_q), 64'd0);
    chk("rst_after_empty", 64'(bus.out_empty), 64'd1);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
